tt_um_serial_tx_madhav_malhotra: RTL and testbench

TT_UM_SERIAL_TX_MADHAV_MALHOTRA -- requirements
Module: tt_um_serial_tx_madhav_malhotra

---
 rtl/tt_um_serial_tx_madhav_malhotra.sv | 154 +++++++++++++++
 tb/tb_tt_um_serial_tx_madhav_malhotra.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_serial_tx_madhav_malhotra.sv
// Serial byte transmitter: a start edge sends 8 data bits MSB first plus even parity,
// framed by cs_n and clocked out on sclk, with abort and a completed-frame counter.
module tt_um_serial_tx_madhav_malhotra #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  localparam logic [8:0] PERIOD_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] HALF        = 9'(CLK_DIV);
  localparam logic [8:0] HOLD_LAST   = 9'(CLK_DIV - 1);

  state_t     r_state;
  logic       r_start_s1, r_start_s2, r_start_s3;
  logic       r_abort_s1, r_abort_s2;
  logic [8:0] r_div;
  logic [3:0] r_bit;
  logic [8:0] r_shift;
  logic       r_sclk, r_sdata, r_cs_n, r_busy;
  logic [7:0] r_frames;

  state_t     w_state_next;
  logic [8:0] w_div_next;
  logic [3:0] w_bit_next;
  logic [8:0] w_shift_next;
  logic       w_sclk_next, w_sdata_next, w_cs_n_next, w_busy_next;
  logic [7:0] w_frames_next;
  logic       w_start_edge, w_abort;

  // Power-good and the spare uio_in bits carry no meaning for this block.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, ena, uio_in[7:6], uio_in[3:0]};

  assign w_start_edge = r_start_s2 & ~r_start_s3;
  assign w_abort      = r_abort_s2;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next  = r_state;
    w_div_next    = r_div;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_frames_next = r_frames;
    w_sclk_next   = 1'b0;
    w_sdata_next  = 1'b0;
    w_cs_n_next   = 1'b1;
    w_busy_next   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_edge && !w_abort) begin
          w_state_next = S_SHIFT;
          w_div_next   = '0;
          w_bit_next   = '0;
          w_shift_next = {ui_in, ^ui_in};
        end
      end
      S_SHIFT: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else if (r_div == PERIOD_LAST) begin
          w_div_next = '0;
          if (r_bit == 4'd8) begin
            w_state_next = S_HOLD;
          end else begin
            w_bit_next   = r_bit + 4'd1;
            w_shift_next = {r_shift[7:0], 1'b0};
          end
        end else begin
          w_div_next = r_div + 9'd1;
        end
      end
      S_HOLD: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else if (r_div == HOLD_LAST) begin
          w_state_next  = S_IDLE;
          w_frames_next = r_frames + 8'd1;
        end else begin
          w_div_next = r_div + 9'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Pins are decoded from the next state so every output comes straight off a flop.
    case (w_state_next)
      S_SHIFT: begin
        w_sclk_next  = (w_div_next >= HALF);
        w_sdata_next = w_shift_next[8];
        w_cs_n_next  = 1'b0;
        w_busy_next  = 1'b1;
      end
      S_HOLD: begin
        w_cs_n_next = 1'b0;
        w_busy_next = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_s3 <= 1'b0;
      r_abort_s1 <= 1'b0;
      r_abort_s2 <= 1'b0;
      r_div      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_sclk     <= 1'b0;
      r_sdata    <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_frames   <= '0;
    end else begin
      r_start_s1 <= uio_in[4];
      r_start_s2 <= r_start_s1;
      r_start_s3 <= r_start_s2;
      r_abort_s1 <= uio_in[5];
      r_abort_s2 <= r_abort_s1;
      r_state    <= w_state_next;
      r_div      <= w_div_next;
      r_bit      <= w_bit_next;
      r_shift    <= w_shift_next;
      r_sclk     <= w_sclk_next;
      r_sdata    <= w_sdata_next;
      r_cs_n     <= w_cs_n_next;
      r_busy     <= w_busy_next;
      r_frames   <= w_frames_next;
    end
  end

  assign uio_out = {4'b0000, r_busy, r_cs_n, r_sdata, r_sclk};
  assign uio_oe  = 8'h0F;
  assign uo_out  = r_frames;

endmodule

// File: tb/tb_tt_um_serial_tx_madhav_malhotra.sv
// Bench for the serial transmitter: two instances (CLK_DIV=4 and CLK_DIV=1) checked every
// cycle against a frame-timeline model, plus literal expectations for known frames.
module tb_tt_um_serial_tx_madhav_malhotra;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] ui4, uioin4, uio_out4, uio_oe4, uo4;
  logic [7:0] ui1, uioin1, uio_out1, uio_oe1, uo1;

  tt_um_serial_tx_madhav_malhotra #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .ena(1'b1), .ui_in(ui4), .uio_in(uioin4),
    .uio_out(uio_out4), .uio_oe(uio_oe4), .uo_out(uo4)
  );

  tt_um_serial_tx_madhav_malhotra #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .ena(1'b1), .ui_in(ui1), .uio_in(uioin1),
    .uio_out(uio_out1), .uio_oe(uio_oe1), .uo_out(uo1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: k counts cycles since the accept edge; the frame is a fixed
  // 19*D-cycle timeline of 9 bit periods followed by a D-cycle hold.
  typedef struct packed {
    logic [2:0] st_h;
    logic [1:0] ab_h;
    logic       active;
    int         k;
    logic [8:0] bits;
    logic [7:0] cnt;
  } model_t;

  function automatic model_t step(input model_t m, input int d, input logic st,
                                  input logic ab, input logic [7:0] ui);
    logic edge_seen, abort_seen;
    edge_seen  = m.st_h[1] & ~m.st_h[2];
    abort_seen = m.ab_h[1];
    if (!m.active) begin
      if (edge_seen && !abort_seen) begin
        m.active = 1'b1;
        m.k      = 0;
        m.bits   = {ui, ^ui};
      end
    end else if (abort_seen) begin
      m.active = 1'b0;
    end else begin
      m.k++;
      if (m.k == 19 * d) begin
        m.active = 1'b0;
        m.cnt++;
      end
    end
    m.st_h = {m.st_h[1:0], st};
    m.ab_h = {m.ab_h[0], ab};
    return m;
  endfunction

  function automatic logic [7:0] exp_uio(input model_t m, input int d);
    logic sclk, sdata;
    if (!m.active) return 8'h04;
    if (m.k < 18 * d) begin
      sclk  = ((m.k % (2 * d)) >= d);
      sdata = m.bits[8 - m.k / (2 * d)];
      return {4'b0000, 1'b1, 1'b0, sdata, sclk};
    end
    return 8'h08;
  endfunction

  model_t m4, m1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 <= '0;
      m1 <= '0;
    end else begin
      m4 <= step(m4, 4, uioin4[4], uioin4[5], ui4);
      m1 <= step(m1, 1, uioin1[4], uioin1[5], ui1);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("uio_out_div4", uio_out4, exp_uio(m4, 4));
      check("uo_out_div4", uo4, m4.cnt);
      check("uio_oe_div4", uio_oe4, 8'h0F);
      check("uio_out_div1", uio_out1, exp_uio(m1, 1));
      check("uo_out_div1", uo1, m1.cnt);
      check("uio_oe_div1", uio_oe1, 8'h0F);
    end
  end

  // Line monitors: bits seen at sclk rises, cs_n-low window length, frames ended.
  logic       prev_cs4, prev_sclk4, prev_cs1, prev_sclk1;
  int         win4, last_win4, frames4, rises4;
  int         win1, last_win1, frames1;
  logic [8:0] rx4;

  always @(negedge clk) begin
    if (rst) begin
      prev_cs4 <= 1'b1; prev_sclk4 <= 1'b0; win4 <= 0; rises4 <= 0; rx4 <= '0;
    end else begin
      if (!uio_out4[2]) begin
        if (prev_cs4) begin
          win4 <= 1; rx4 <= '0; rises4 <= 0;
        end else begin
          win4 <= win4 + 1;
          if (uio_out4[0] && !prev_sclk4) begin
            rx4    <= {rx4[7:0], uio_out4[1]};
            rises4 <= rises4 + 1;
          end
        end
      end else if (!prev_cs4) begin
        last_win4 <= win4;
        frames4   <= frames4 + 1;
      end
      prev_cs4   <= uio_out4[2];
      prev_sclk4 <= uio_out4[0];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_cs1 <= 1'b1; prev_sclk1 <= 1'b0; win1 <= 0;
    end else begin
      if (!uio_out1[2]) begin
        win1 <= prev_cs1 ? 1 : win1 + 1;
      end else if (!prev_cs1) begin
        last_win1 <= win1;
        frames1   <= frames1 + 1;
      end
      prev_cs1   <= uio_out1[2];
      prev_sclk1 <= uio_out1[0];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] ui);
    if (which == 4) begin ui4 = ui; uioin4[4] = 1'b1; end
    else begin ui1 = ui; uioin1[4] = 1'b1; end
    tick();
    tick();
    if (which == 4) uioin4[4] = 1'b0;
    else uioin1[4] = 1'b0;
  endtask

  task automatic wait_frame_end(input int which, input string name);
    int f0;
    f0 = (which == 4) ? frames4 : frames1;
    for (int i = 0; i < 3000; i++) begin
      if (((which == 4) ? frames4 : frames1) != f0) break;
      tick();
    end
    check({name, "_completed"}, (((which == 4) ? frames4 : frames1) != f0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] u0;
    int         f0, w;
    logic       st4, ab4, st1, ab1;

    frames4 = 0; frames1 = 0; last_win4 = 0; last_win1 = 0;
    rst = 1'b1;
    ui4 = '0; uioin4 = '0; ui1 = '0; uioin1 = '0;
    repeat (3) tick();
    check("reset_uio_out", uio_out4, 8'h04);
    check("reset_uo_out", uo4, 8'h00);
    check("reset_uio_oe", uio_oe4, 8'h0F);
    rst = 1'b0;
    repeat (3) tick();

    send(4, 8'hA5);
    wait_frame_end(4, "frame_a5");
    check("a5_bits", rx4, 9'b101001010);
    check("a5_cs_low_cycles", last_win4, 76);
    check("a5_count", uo4, 8'd1);

    tick();
    send(4, 8'h07);
    wait_frame_end(4, "frame_07");
    check("h07_bits", rx4, 9'b000001111);
    check("h07_count", uo4, 8'd2);

    for (int i = 0; i < 6; i++) begin
      tick();
      send(4, 8'($urandom));
      wait_frame_end(4, "frame_rand");
      check("rand_cs_low_cycles", last_win4, 76);
    end

    // Abort after the third sclk rise.
    u0 = uo4;
    tick();
    send(4, 8'($urandom));
    for (int i = 0; i < 20 && uio_out4[2]; i++) tick();
    check("abort_frame_started", uio_out4[2], 1'b0);
    tick();
    for (int i = 0; i < 200 && rises4 < 3; i++) tick();
    check("abort_third_rise_seen", rises4, 3);
    uioin4[5] = 1'b1;
    w = 0;
    while (!uio_out4[2] && w < 6) begin tick(); w++; end
    check("abort_latency_le3", (w <= 3), 1);
    check("abort_count_kept", uo4, u0);
    uioin4[5] = 1'b0;
    repeat (4) tick();
    send(4, 8'h5A);
    wait_frame_end(4, "after_abort");
    check("after_abort_bits", rx4, 9'b010110100);
    check("after_abort_cs_low", last_win4, 76);
    check("after_abort_count", uo4, u0 + 8'd1);

    // Start held high, with a dip and re-rise while busy.
    u0 = uo4;
    f0 = frames4;
    ui4 = 8'h3C;
    uioin4[4] = 1'b1;
    repeat (30) tick();
    uioin4[4] = 1'b0;
    repeat (4) tick();
    uioin4[4] = 1'b1;
    repeat (466) tick();
    uioin4[4] = 1'b0;
    repeat (5) tick();
    check("held_start_one_frame", frames4, f0 + 1);
    check("held_start_count", uo4, u0 + 8'd1);

    // Random start/abort activity on both instances.
    st4 = 0; ab4 = 0; st1 = 0; ab1 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) st4 = ~st4;
      if ($urandom_range(0, 9) == 0) st1 = ~st1;
      ab4 = ($urandom_range(0, 149) == 0);
      ab1 = ($urandom_range(0, 149) == 0);
      ui4 = 8'($urandom);
      ui1 = 8'($urandom);
      uioin4 = {2'($urandom), ab4, st4, 4'($urandom)};
      uioin1 = {2'($urandom), ab1, st1, 4'($urandom)};
      tick();
    end
    uioin4 = '0;
    uioin1 = '0;
    repeat (200) tick();

    // Reset in the middle of a frame.
    send(4, 8'hC3);
    repeat (20) tick();
    check("midframe_busy", uio_out4[3], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_uio_out", uio_out4, 8'h04);
    check("midframe_rst_uo_out", uo4, 8'h00);
    check("midframe_rst_uio_oe", uio_oe4, 8'h0F);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    send(4, 8'hFF);
    wait_frame_end(4, "after_reset");
    check("after_reset_bits", rx4, 9'b111111110);
    check("after_reset_count", uo4, 8'd1);

    // CLK_DIV=1: 256 back-to-back frames wrap the counter.
    for (int f = 0; f < 256; f++) begin
      send(1, 8'($urandom));
      wait_frame_end(1, "div1_frame");
      check("div1_cs_low_cycles", last_win1, 19);
      if (f == 254) check("div1_count_255", uo1, 8'd255);
    end
    check("div1_count_wrap", uo1, 8'd0);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
